hash_kw_gen: RTL
================

# hash_kw_gen

Message-schedule generator for the SHA-256/SHA-384 round datapath. It accepts one 16-word message block, expands it into the round schedule W[t], and adds the round constant K[t]. It drives the K+W stream that the hash round function consumes: `kw`, `kw_vld`, `kw_flg0` and `kw_done`, one round per beat. It sits between the block buffer and the round function, and the control unit starts it.

## Interface
- `ROUNDS_256`, default 64: round count in SHA-256 mode.
- `ROUNDS_384`, default 80: round count in SHA-384 mode.
- `clk` in, 1: system clock.
- `rst` in, 1: reset. One clock; reset is synchronous and active-high.
- `start` in, 1: single-cycle pulse that begins a block. Ignored while `busy`=1.
- `h_flg_384` in, 1: mode select, sampled at `start`. 1 selects SHA-384; 0 selects SHA-256.
- `msg_vld` in, 1: message word valid.
- `msg_word` in, 64: message word. In SHA-256 mode the word occupies [63:32] and [31:0] is ignored.
- `msg_rdy` out, 1: ready to accept a message word.
- `k_addr` out, 7: round-constant ROM address, equal to t.
- `k_data` in, 64: round constant, combinational from `k_addr`. SHA-256 constants sit in [63:32].
- `kw` out, 64: K[t]+W[t].
- `kw_vld` out, 1: `kw` beat valid.
- `kw_flg0` out, 1: marks the round-0 beat.
- `kw_done` out, 1: marks the final flush beat.
- `busy` out, 1: block in progress.

## Operation
- **States:**
  - IDLE: on `start`, latch `mode_384`, clear t, go to LOAD.
  - LOAD: t = 0..15.
  - EXPAND: t = 16..N-1, where N = `ROUNDS_384` if `mode_384`, else `ROUNDS_256`.
  - FLUSH: one beat, then return to IDLE.
- **LOAD:**
  - `msg_rdy`=1.
  - Each handshake (`msg_vld` & `msg_rdy`) sets W[t] = `msg_word` and shifts it into the 16-entry W window.
  - The same handshake issues one kw beat and increments t.
  - Cycles without a handshake issue no beat; gaps are legal.
  - After the handshake at t=15, go to EXPAND.
- **EXPAND:**
  - `msg_rdy`=0.
  - One beat every cycle with no stalls.
  - W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], computed from the window.
  - After t = N-1, go to FLUSH.
- **σ functions:**
  - SHA-256, computed on 32 bits: σ0 = ror7^ror18^shr3; σ1 = ror17^ror19^shr10.
  - SHA-384, computed on 64 bits: σ0 = ror1^ror8^shr7; σ1 = ror19^ror61^shr6.
- **Arithmetic:**
  - SHA-256: all sums are modulo 2^32 on bits [63:32], and `kw`[31:0] = 0.
  - SHA-384: all sums are modulo 2^64.
- **Beat flags:**
  - `kw_flg0`=1 only on the t=0 beat.
  - FLUSH beat: `kw_vld`=1, `kw_done`=1, `kw`=0.
  - Total per block: N+1 beats.
- **Control:**
  - `start` while `busy`=1 has no effect.
  - `h_flg_384` changes after `start` have no effect until the next block.
- **Reset:**
  - Clears the state to IDLE, t, the window and `mode_384`.
  - Any block in progress is abandoned, with no flush beat.

## Timing
- Reset values: `msg_rdy`=0, `kw`=0, `kw_vld`=0, `kw_flg0`=0, `kw_done`=0, `busy`=0, `k_addr`=0.
- `kw`, `kw_vld`, `kw_flg0` and `kw_done` are registered.
- A beat for round t, whether from a handshake or an EXPAND step in cycle c, appears at c+1.
- `start` in cycle s:
  - `busy`=1 and `msg_rdy`=1 from s+1.
  - With `msg_vld` held high, word 0 is accepted at s+1 and `kw` beat 0 appears at s+2.
  - Beat t appears at s+2+t.
  - The FLUSH beat appears at s+2+N: s+66 for SHA-256, s+82 for SHA-384.
- `busy` stays 1 through the FLUSH beat cycle and falls at the next cycle.
- A new `start` is accepted in the cycle after `busy` falls.
- `k_addr` equals t combinationally during LOAD and EXPAND, and the sum uses `k_data` from the same cycle.

## Test plan
- **SHA-256 "abc":** W0=0x61626380, W1..W14=0, W15=0x18, back-to-back `msg_vld`.
  - Beat 0: `kw`=0xa3ec9318_00000000, `kw_flg0`=1.
  - Beat 15: 0xc19bf18c_00000000.
  - Beat 16: 0x45fdcd41_00000000.
  - Beat 64: `kw_done`=1, `kw`=0.
  - 65 beats in total.
- **SHA-384 "abc":** W0=0x6162638000000000, W15=0x18, all other words 0.
  - Beat 0: `kw`=0xa3ec9318d728ae22.
  - Beat 80 is the flush beat, and `busy` falls at s+83.
- **Message gaps:** `msg_vld` toggled 1/0 during LOAD.
  - `kw_vld` is low exactly in the cycles after non-handshake cycles.
  - The kw values are identical to the gap-free run.
- **`start` while busy:** `start` pulsed at t=30.
  - No restart, and the beat sequence is unchanged.
  - A `start` the cycle after `busy` falls begins a new block.
- **Reset at t=40:** assert `rst` for 1 cycle.
  - The next cycle shows all outputs at reset values and no `kw_done`.
  - A fresh `start` reproduces beat 0 correctly.

Source files
------------

// File: rtl/hash_kw_gen.sv
// SHA-256/384 message schedule: streams K[t]+W[t] one round per beat, N+1 beats per block (last is a zero flush).
// Beats are registered one cycle after their handshake/expand step; msg_rdy only in LOAD, EXPAND never stalls.
module hash_kw_gen #(
  parameter int ROUNDS_256 = 64,
  parameter int ROUNDS_384 = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        h_flg_384,
  input  logic        msg_vld,
  input  logic [63:0] msg_word,
  output logic        msg_rdy,
  output logic [6:0]  k_addr,
  input  logic [63:0] k_data,
  output logic [63:0] kw,
  output logic        kw_vld,
  output logic        kw_flg0,
  output logic        kw_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, FLUSH} state_t;

  state_t      state;
  logic [6:0]  t;
  logic        mode_384;
  logic [63:0] win [16];  // win[15] holds W[t-1], win[0] holds W[t-16]

  logic [31:0] w_exp_256;
  logic [31:0] kw_hi_256;
  logic [63:0] w_exp_384;
  logic [63:0] w_load;
  logic [63:0] w_cur;
  logic [63:0] kw_sum;
  logic [6:0]  t_last;
  logic        hs;
  logic        step;

  function automatic logic [31:0] s0_256(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1_256(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0] s0_384(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] s1_384(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  assign msg_rdy = (state == LOAD);
  assign k_addr  = (state == LOAD || state == EXPAND) ? t : 7'd0;
  assign hs      = msg_vld & msg_rdy;
  assign step    = hs | (state == EXPAND);
  assign t_last  = mode_384 ? 7'(ROUNDS_384 - 1) : 7'(ROUNDS_256 - 1);

  // SHA-256 words live in [63:32] with the low half kept at zero throughout
  assign w_load    = mode_384 ? msg_word : {msg_word[63:32], 32'h0};
  assign w_exp_256 = s1_256(win[14][63:32]) + win[9][63:32]
                   + s0_256(win[1][63:32]) + win[0][63:32];
  assign w_exp_384 = s1_384(win[14]) + win[9] + s0_384(win[1]) + win[0];
  assign w_cur     = (state == LOAD) ? w_load
                   : (mode_384 ? w_exp_384 : {w_exp_256, 32'h0});
  assign kw_hi_256 = k_data[63:32] + w_cur[63:32];
  assign kw_sum    = mode_384 ? (k_data + w_cur) : {kw_hi_256, 32'h0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      t        <= 7'd0;
      mode_384 <= 1'b0;
      busy     <= 1'b0;
      kw       <= 64'h0;
      kw_vld   <= 1'b0;
      kw_flg0  <= 1'b0;
      kw_done  <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= 64'h0;
    end else begin
      kw      <= 64'h0;
      kw_vld  <= 1'b0;
      kw_flg0 <= 1'b0;
      kw_done <= 1'b0;

      if (step) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_cur;
        kw      <= kw_sum;
        kw_vld  <= 1'b1;
        kw_flg0 <= (t == 7'd0);
        t       <= t + 7'd1;
      end

      case (state)
        IDLE: begin
          // busy is still high in the cycle the flush beat is visible, so start is ignored there
          busy <= start & ~busy;
          if (start && !busy) begin
            mode_384 <= h_flg_384;
            t        <= 7'd0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (hs && t == 7'd15) state <= EXPAND;
        end
        EXPAND: begin
          if (t == t_last) state <= FLUSH;
        end
        FLUSH: begin
          kw_vld  <= 1'b1;
          kw_done <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
